// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO in front of data_mem; loads drain queued stores first, then pass through.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_busy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_HI = 2'd2, WAIT_LO = 2'd3;
  logic [31:0] q_addr [DEPTH];
  logic [31:0] q_data [DEPTH];
  logic [3:0]  q_mask [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0] count;
  logic [1:0] state, nstate;
  logic op_ld, ld_done, full, push, issue_st, issue_ld, ld_fin;
  always_comb begin
    full      = count == (PTR_W+1)'(DEPTH);
    push      = cpu_memwrite & ~full;
    issue_st  = (state == IDLE) & ~mem_busy & (count != '0);
    issue_ld  = (state == IDLE) & ~mem_busy & (count == '0) & cpu_memread & ~ld_done;
    ld_fin    = (state == WAIT_LO) & ~mem_busy & op_ld;
    cpu_stall = (cpu_memwrite & full) | (cpu_memread & ~ld_done);
    nstate    = (state == IDLE)    ? ((issue_st | issue_ld) ? ISSUE : IDLE) :
                (state == ISSUE)   ? WAIT_HI :
                (state == WAIT_HI) ? (mem_busy ? WAIT_LO : WAIT_HI) :
                                     (mem_busy ? WAIT_LO : IDLE);
  end
  // entry storage carries no reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= cpu_addr;
      q_data[wr_ptr] <= cpu_write_data;
      q_mask[wr_ptr] <= cpu_sign_mask;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count          <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      state          <= IDLE;
      op_ld          <= 1'b0;
      ld_done        <= 1'b0;
      cpu_read_data  <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_sign_mask  <= '0;
    end else begin
      state        <= nstate;
      count        <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, issue_st};
      wr_ptr       <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr       <= issue_st ? rd_ptr + 1'b1 : rd_ptr;
      op_ld        <= issue_ld ? 1'b1 : issue_st ? 1'b0 : op_ld;
      ld_done      <= ld_fin;
      mem_memwrite <= issue_st;
      mem_memread  <= issue_ld;
      if (ld_fin) cpu_read_data <= mem_read_data;
      if (issue_st) begin
        mem_addr       <= q_addr[rd_ptr];
        mem_write_data <= q_data[rd_ptr];
        mem_sign_mask  <= q_mask[rd_ptr];
      end else if (issue_ld) begin
        mem_addr      <= cpu_addr;
        mem_sign_mask <= cpu_sign_mask;
      end
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: randomized scoreboard bench with a data_mem stub and a word-level memory reference.
module tb_store_buffer;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic [31:0] cpu_addr = 0, cpu_write_data = 0, cpu_read_data, mem_addr, mem_write_data, mem_read_data;
  logic cpu_memwrite = 0, cpu_memread = 0, cpu_stall, mem_memwrite, mem_memread, mem_busy;
  logic [3:0] cpu_sign_mask = 0, mem_sign_mask;
  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
    .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread), .cpu_sign_mask(cpu_sign_mask),
    .cpu_read_data(cpu_read_data), .cpu_stall(cpu_stall), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data), .mem_busy(mem_busy));
  typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] m;} wr_t;
  typedef struct {logic [31:0] a; logic [31:0] d;} rd_t;
  wr_t exp_wr[$];
  rd_t exp_rd[$];
  logic [31:0] mem_arr[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  int checks = 0, errors = 0, wr_pulses = 0, rd_pulses = 0, bcnt = 0;
  logic hold = 0;
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction
  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with nothing expected", name);
  endtask
  // data_mem stub: busy for two cycles after each request pulse; hold stretches busy
  assign mem_busy = hold | (bcnt != 0);
  always @(posedge clk) begin
    bcnt <= (mem_memwrite | mem_memread) ? 2 : (bcnt != 0) ? bcnt - 1 : 0;
    if (mem_memwrite) mem_arr[mem_addr] = mem_write_data;
    if (mem_memread) mem_read_data <= mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : dflt(mem_addr);
  end
  always @(negedge clk) begin
    #2;
    if (mem_memwrite) begin
      wr_pulses++;
      if (exp_wr.size() == 0) fail("unexpected_write");
      else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("bus_write", {mem_addr, mem_write_data, mem_sign_mask}, {e.a, e.d, e.m});
      end
    end
    if (mem_memread) begin
      rd_pulses++;
      if (exp_rd.size() == 0) fail("unexpected_read");
      else check("load_addr", 68'(mem_addr), 68'(exp_rd[0].a));
    end
    if (cpu_memread && !cpu_stall) begin
      if (exp_rd.size() == 0) fail("unexpected_load_data");
      else begin
        rd_t e;
        e = exp_rd.pop_front();
        check("load_data", 68'(cpu_read_data), 68'(e.d));
      end
    end
  end
  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, output int stalls);
    @(negedge clk);
    cpu_addr = a; cpu_write_data = d; cpu_sign_mask = m; cpu_memwrite = 1; stalls = 0;
    #1;
    while (cpu_stall && stalls < 300) begin stalls++; @(negedge clk); #1; end
    if (cpu_stall) begin checks++; errors++; $display("FAIL store_timeout: stalled %0d cycles, required < 300", stalls); end
    else begin exp_wr.push_back('{a, d, m}); ref_mem[a] = d; end
    @(posedge clk); #1;
    cpu_memwrite = 0;
  endtask
  task automatic ld(input logic [31:0] a, output int stalls);
    @(negedge clk);
    exp_rd.push_back('{a, ref_mem.exists(a) ? ref_mem[a] : dflt(a)});
    cpu_addr = a; cpu_sign_mask = 4'b0010; cpu_memread = 1; stalls = 0;
    #1;
    while (cpu_stall && stalls < 300) begin stalls++; @(negedge clk); #1; end
    if (cpu_stall) begin checks++; errors++; $display("FAIL load_timeout: stalled %0d cycles, required < 300", stalls); end
    @(posedge clk); #1;
    cpu_memread = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 500 && (exp_wr.size() != 0 || exp_rd.size() != 0); i++) @(negedge clk);
    repeat (8) @(negedge clk);
    check("drain_empty", 68'(exp_wr.size() + exp_rd.size()), 68'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int s, p0, sv[7];
    repeat (3) @(negedge clk);
    check("reset_outputs", {cpu_read_data, mem_memwrite, mem_memread, cpu_stall, mem_addr[28:0]}, 68'd0);
    check("reset_count", 68'(dut.count), 68'd0);
    @(negedge clk); reset = 0;
    // 1: single store, no stall, one bus write
    p0 = wr_pulses;
    st(32'h4000, 32'h1234_5678, 4'b0010, s);
    check("t1_nostall", 68'(s), 68'd0);
    repeat (10) @(negedge clk);
    check("t1_one_pulse", 68'(wr_pulses - p0), 68'd1);
    // 2: five stores against a blocked memory; the fifth waits for the first pop
    hold = 1;
    fork begin repeat (12) @(negedge clk); hold = 0; end join_none
    for (int i = 0; i < 5; i++) st(32'h5000 + 32'(4 * i), 32'hA000 + 32'(i), 4'b0010, sv[i]);
    for (int i = 0; i < 4; i++) check("t2_nostall", 68'(sv[i]), 68'd0);
    check("t2_fifth_stalls", 68'(sv[4] > 2), 68'd1);
    drain();
    // 3: store then load of the same word
    st(32'h4004, 32'h0000_00AA, 4'b0010, s);
    ld(32'h4004, s);
    check("t3_load_behind_store", 68'(s > 5), 68'd1);
    drain();
    // 4: load with idle memory and empty FIFO
    p0 = rd_pulses;
    ld(32'h4400, s);
    check("t4_stall_cycles", 68'(s), 68'd5);
    repeat (10) @(negedge clk);
    check("t4_one_read_pulse", 68'(rd_pulses - p0), 68'd1);
    // 5: reset while a store is in its busy window with three more queued
    hold = 1;
    for (int i = 0; i < 4; i++) st(32'h6000 + 32'(4 * i), 32'hB000 + 32'(i), 4'b1111, s);
    @(negedge clk); hold = 0;
    for (int i = 0; i < 20 && !mem_memwrite; i++) @(negedge clk);
    @(negedge clk); hold = 1;
    @(negedge clk); reset = 1; exp_wr.delete();
    p0 = wr_pulses;
    @(negedge clk); reset = 0;
    check("t5_count_cleared", 68'(dut.count), 68'd0);
    check("t5_read_data_cleared", 68'(cpu_read_data), 68'd0);
    repeat (4) @(negedge clk);
    hold = 0;
    repeat (12) @(negedge clk);
    check("t5_no_write_after_reset", 68'(wr_pulses - p0), 68'd0);
    mem_arr.delete(); ref_mem.delete();
    // 6: DEPTH+3 stores, pointers wrap
    hold = 1;
    p0 = wr_pulses;
    fork begin repeat (10) @(negedge clk); hold = 0; end join_none
    for (int i = 0; i < 7; i++) st(32'h2000 + 32'(4 * i), $urandom, 4'(i), s);
    drain();
    check("t6_all_delivered", 68'(wr_pulses - p0), 68'd7);
    check("t6_count_zero", 68'(dut.count), 68'd0);
    // random mix over a small address window so loads hit recent stores
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = 32'h4000 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 2) != 2) st(a, $urandom, 4'($urandom_range(0, 15)), s);
      else ld(a, s);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    check("final_count_zero", 68'(dut.count), 68'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
